// File: rtl/sap_controller_sequencer.sv
// SAP-1 controller/sequencer: one-hot T-state ring counter clocked on the
// falling edge, plus a live decoder producing the 12-bit control word.
module sap_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [3:0]  opcode,
  output logic [11:0] con,
  output logic [5:0]  t_state,
  output logic        hlt
);

  localparam int unsigned CON_W = 12;

  // Control word bit positions
  localparam int unsigned B_CP = 11;
  localparam int unsigned B_EP = 10;
  localparam int unsigned B_LM = 9;
  localparam int unsigned B_CE = 8;
  localparam int unsigned B_LI = 7;
  localparam int unsigned B_EI = 6;
  localparam int unsigned B_LA = 5;
  localparam int unsigned B_EA = 4;
  localparam int unsigned B_SU = 3;
  localparam int unsigned B_EU = 2;
  localparam int unsigned B_LB = 1;
  localparam int unsigned B_LO = 0;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e state_q;
  logic     halted_q;
  logic     halt_now;

  // HLT is recognised in T4 before the halted flag is registered
  assign halt_now = (state_q == T4) && (opcode == OP_HLT);
  assign hlt      = halted_q | halt_now;
  assign t_state  = state_q;

  // Ring counter and halted flag advance on the falling edge; clear wins
  always_ff @(negedge clk or posedge clear) begin
    if (clear) begin
      state_q  <= T1;
      halted_q <= 1'b0;
    end else if (halted_q) begin
      state_q  <= T4;
    end else if (halt_now) begin
      halted_q <= 1'b1;
      state_q  <= T4;
    end else begin
      case (state_q)
        T1:      state_q <= T2;
        T2:      state_q <= T3;
        T3:      state_q <= T4;
        T4:      state_q <= T5;
        T5:      state_q <= T6;
        T6:      state_q <= T1;
        default: state_q <= T1;  // recover from a corrupted ring
      endcase
    end
  end

  // Control word decode from current T-state and live opcode
  always_comb begin
    con = '0;
    if (!halted_q) begin
      case (state_q)
        T1: begin
          con[B_EP] = 1'b1;
          con[B_LM] = 1'b1;
        end
        T2: con[B_CP] = 1'b1;
        T3: begin
          con[B_CE] = 1'b1;
          con[B_LI] = 1'b1;
        end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            con[B_EI] = 1'b1;
            con[B_LM] = 1'b1;
          end else if (opcode == OP_OUT) begin
            con[B_EA] = 1'b1;
            con[B_LO] = 1'b1;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            con[B_CE] = 1'b1;
            con[B_LA] = 1'b1;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            con[B_CE] = 1'b1;
            con[B_LB] = 1'b1;
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            con[B_EU] = 1'b1;
            con[B_LA] = 1'b1;
            con[B_SU] = (opcode == OP_SUB);
          end
        end
        default: con = CON_W'(0);
      endcase
    end
  end

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Bench for sap_controller_sequencer: instruction-level reference model,
// directed programs, randomized opcode stream, halt and reset scenarios.
module tb_sap_controller_sequencer;

  logic        clk;
  logic        clear;
  logic [3:0]  opcode;
  logic [11:0] con;
  logic [5:0]  t_state;
  logic        hlt;

  int checks;
  int errors;

  // Reference model: phase index 0..5 (T1..T6) and halted flag
  int ph;
  bit m_halted;

  sap_controller_sequencer dut (
    .clk     (clk),
    .clear   (clear),
    .opcode  (opcode),
    .con     (con),
    .t_state (t_state),
    .hlt     (hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word from the instruction micro-step table
  function automatic logic [11:0] exp_con(int p, logic [3:0] op, bit halted);
    if (halted) return 12'h000;
    case (p)
      0: return 12'h600;
      1: return 12'h800;
      2: return 12'h180;
      default: begin
        case (op)
          4'h0: return (p == 3) ? 12'h240 : (p == 4) ? 12'h120 : 12'h000;
          4'h1: return (p == 3) ? 12'h240 : (p == 4) ? 12'h102 : 12'h024;
          4'h2: return (p == 3) ? 12'h240 : (p == 4) ? 12'h102 : 12'h02C;
          4'hE: return (p == 3) ? 12'h011 : 12'h000;
          default: return 12'h000;
        endcase
      end
    endcase
  endfunction

  task automatic model_step();
    if (m_halted) ph = 3;
    else if (ph == 3 && opcode == 4'hF) m_halted = 1'b1;
    else ph = (ph + 1) % 6;
  endtask

  task automatic check(string tag);
    logic [5:0]  et;
    logic [11:0] ec;
    logic        eh;
    et = 6'(1 << ph);
    ec = exp_con(ph, opcode, m_halted);
    eh = m_halted || (ph == 3 && opcode == 4'hF);
    checks++;
    assert (t_state === et) else begin
      errors++;
      $error("FAIL %s t_state got %b exp %b", tag, t_state, et);
    end
    checks++;
    assert (con === ec) else begin
      errors++;
      $error("FAIL %s con got %h exp %h", tag, con, ec);
    end
    checks++;
    assert (hlt === eh) else begin
      errors++;
      $error("FAIL %s hlt got %b exp %b", tag, hlt, eh);
    end
  endtask

  // One full clock: check after the falling edge and after the rising edge
  task automatic tick(string tag);
    @(negedge clk);
    model_step();
    #1 check({tag, "_neg"});
    @(posedge clk);
    #1 check({tag, "_pos"});
  endtask

  // Async clear pulse placed between edges
  task automatic pulse_clear(string tag);
    clear = 1'b1;
    #1;
    ph = 0;
    m_halted = 1'b0;
    check({tag, "_clr"});
    #1 clear = 1'b0;
  endtask

  // Run one instruction starting in T1: opcode set during fetch
  task automatic run_instr(logic [3:0] op, string tag);
    opcode = op;
    for (int i = 0; i < 6; i++) tick(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ph = 0;
    m_halted = 1'b0;
    opcode = 4'h0;
    clear = 1'b1;
    #1 check("reset");
    @(posedge clk);
    #1 check("reset_hold");
    clear = 1'b0;

    // Directed programs
    run_instr(4'h0, "lda");
    run_instr(4'h1, "add");
    run_instr(4'h2, "sub");
    run_instr(4'hE, "out");
    run_instr(4'h7, "nop");

    // Clear mid-T5 of ADD, then release and step to T2
    opcode = 4'h1;
    for (int i = 0; i < 4; i++) tick("add_pre");
    pulse_clear("mid_t5");
    tick("after_clr");
    for (int i = 0; i < 5; i++) tick("after_clr_run");

    // Halt, stay halted for 10 cycles, then clear out
    run_instr(4'hF, "hlt");
    for (int i = 0; i < 10; i++) tick("halted");
    pulse_clear("hlt_exit");
    for (int i = 0; i < 6; i++) tick("post_hlt");

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      run_instr(4'($urandom_range(0, 15)), "rand");
      if (m_halted) begin
        for (int i = 0; i < 3; i++) tick("rand_halted");
        pulse_clear("rand_clr");
        for (int i = 0; i < 6; i++) tick("rand_recover");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
